// File: rtl/apb3_resp_pkg.sv
// Shared definitions for the APB3 register responder: FSM encoding,
// register geometry and the access-error rule.
package apb3_resp_pkg;

  localparam int unsigned REG_W   = 32;
  localparam int unsigned IDX_LSB = 2;
  localparam int unsigned IDX_W   = 4;

  // FSM encoding; the remaining code (2'b11) recovers to IDLE.
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_WAIT = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Error when the index is beyond the bank or a write targets the ID register.
  function automatic logic accessError(input logic [IDX_W-1:0] idx,
                                       input logic             write,
                                       input int unsigned      numRegs);
    return (32'(idx) >= numRegs) || (write && (idx == '0));
  endfunction

endpackage

// File: rtl/apb3_resp_regbank.sv
// Register array for the APB3 responder.
// Register 0 is the constant ID_VALUE; registers 1..NUM_REGS-1 are writable.
// Ports: HCLK/HRESETN clock and sync active-low reset; wrEn/wrIdx/wrData
// write port; rdIdx/rdData_c combinational read mux; REG_OUT flattened bank.
module apb3_resp_regbank
  import apb3_resp_pkg::*;
#(
  parameter int unsigned       NUM_REGS = 8,
  parameter logic [REG_W-1:0]  ID_VALUE = 32'hA0B3_0001
) (
  input  logic                        HCLK,
  input  logic                        HRESETN,
  input  logic                        wrEn,
  input  logic [IDX_W-1:0]            wrIdx,
  input  logic [REG_W-1:0]            wrData,
  input  logic [IDX_W-1:0]            rdIdx,
  output logic [REG_W-1:0]            rdData_c,
  output logic [NUM_REGS*REG_W-1:0]   REG_OUT
);

  logic [REG_W-1:0] regs [1:NUM_REGS-1];

  // Write port; index decoded per register to keep index widths exact.
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      for (int i = 1; i < int'(NUM_REGS); i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        if (wrEn && (wrIdx == IDX_W'(i))) regs[i] <= wrData;
      end
    end
  end

  // Read mux; indices outside the bank return zero.
  always_comb begin
    rdData_c = '0;
    if (rdIdx == '0) rdData_c = ID_VALUE;
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      if (rdIdx == IDX_W'(i)) rdData_c = regs[i];
    end
  end

  assign REG_OUT[REG_W-1:0] = ID_VALUE;
  for (genvar g = 1; g < int'(NUM_REGS); g++) begin : gRegOut
    assign REG_OUT[g*REG_W +: REG_W] = regs[g];
  end

endmodule

// File: rtl/apb3_reg_responder.sv
// APB3 completer with a small register bank, fixed wait-state insertion
// through a registered PREADY, PSLVERR on bad accesses and a sticky
// protocol-violation flag.
// Ports: HCLK, HRESETN (sync active-low); APB3 PSEL/PENABLE/PWRITE/PADDR/
// PWDATA in, PRDATA/PREADY/PSLVERR out; PROT_ERR sticky flag; REG_OUT bank.
module apb3_reg_responder
  import apb3_resp_pkg::*;
#(
  parameter int unsigned      ADDR_WIDTH  = 8,
  parameter int unsigned      NUM_REGS    = 8,
  parameter int unsigned      WAIT_STATES = 2,
  parameter logic [REG_W-1:0] ID_VALUE    = 32'hA0B3_0001
) (
  input  logic                       HCLK,
  input  logic                       HRESETN,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [ADDR_WIDTH-1:0]      PADDR,
  input  logic [REG_W-1:0]           PWDATA,
  output logic [REG_W-1:0]           PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic                       PROT_ERR,
  output logic [NUM_REGS*REG_W-1:0]  REG_OUT
);

  localparam logic [IDX_W-1:0] WS = IDX_W'(WAIT_STATES);

  logic [1:0]            state, stateNext;
  logic [IDX_W-1:0]      cnt, cntNext;
  logic [ADDR_WIDTH-1:0] addrQ;
  logic                  writeQ;
  logic [REG_W-1:0]      wdataQ;
  logic                  errQ;

  logic                  readyNext, slverrNext, protSet, capture, wrEn;
  logic [REG_W-1:0]      rdataNext, rdData_c;
  logic [IDX_W-1:0]      idxIn, idxQ, rdIdx;
  logic                  setupErr, mismatch, accessHeld;

  assign idxIn      = PADDR[IDX_LSB +: IDX_W];
  assign idxQ       = addrQ[IDX_LSB +: IDX_W];
  assign setupErr   = accessError(idxIn, PWRITE, NUM_REGS);
  assign mismatch   = (PADDR != addrQ) || (PWRITE != writeQ);
  assign accessHeld = PSEL && PENABLE;

  // State register.
  always_ff @(posedge HCLK) begin
    if (!HRESETN) state <= ST_IDLE;
    else          state <= stateNext;
  end

  // Next state, completion outputs and datapath controls.
  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    readyNext  = 1'b0;
    rdataNext  = '0;
    slverrNext = 1'b0;
    protSet    = 1'b0;
    capture    = 1'b0;
    wrEn       = 1'b0;
    rdIdx      = idxQ;
    case (state)
      ST_IDLE: begin
        if (PSEL) begin
          if (PENABLE) begin
            protSet = 1'b1;
          end else begin
            capture = 1'b1;
            cntNext = WS;
            if (WAIT_STATES == 0) begin
              // Zero wait states: completion is registered straight from setup.
              stateNext  = ST_DONE;
              readyNext  = 1'b1;
              slverrNext = setupErr;
              rdIdx      = idxIn;
              rdataNext  = (PWRITE || setupErr) ? '0 : rdData_c;
            end else begin
              stateNext = ST_WAIT;
            end
          end
        end
      end
      ST_WAIT: begin
        if (!accessHeld) begin
          // Abandoned transfer: back to IDLE without completing.
          protSet   = 1'b1;
          stateNext = ST_IDLE;
          cntNext   = '0;
        end else begin
          protSet = mismatch;
          cntNext = cnt - 1'b1;
          if (cnt == IDX_W'(1)) begin
            stateNext  = ST_DONE;
            readyNext  = 1'b1;
            slverrNext = errQ;
            rdataNext  = (writeQ || errQ) ? '0 : rdData_c;
          end
        end
      end
      ST_DONE: begin
        stateNext = ST_IDLE;
        if (!accessHeld) begin
          protSet = 1'b1;
        end else begin
          protSet = mismatch;
          wrEn    = writeQ && !errQ;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Registered outputs, wait counter, transfer latches and sticky error.
  always_ff @(posedge HCLK) begin
    if (!HRESETN) begin
      cnt      <= '0;
      PREADY   <= 1'b0;
      PRDATA   <= '0;
      PSLVERR  <= 1'b0;
      PROT_ERR <= 1'b0;
      addrQ    <= '0;
      writeQ   <= 1'b0;
      wdataQ   <= '0;
      errQ     <= 1'b0;
    end else begin
      cnt     <= cntNext;
      PREADY  <= readyNext;
      PRDATA  <= rdataNext;
      PSLVERR <= slverrNext;
      if (protSet) PROT_ERR <= 1'b1;
      if (capture) begin
        addrQ  <= PADDR;
        writeQ <= PWRITE;
        wdataQ <= PWDATA;
        errQ   <= setupErr;
      end
    end
  end

  apb3_resp_regbank #(
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) uRegbank (
    .HCLK     (HCLK),
    .HRESETN  (HRESETN),
    .wrEn     (wrEn),
    .wrIdx    (idxQ),
    .wrData   (wdataQ),
    .rdIdx    (rdIdx),
    .rdData_c (rdData_c),
    .REG_OUT  (REG_OUT)
  );

endmodule

// File: tb/tb_apb3_reg_responder.sv
// Directed bench for apb3_reg_responder: one instance with two wait states
// and one with zero wait states share the APB input bus.
module tb_apb3_reg_responder;

  localparam logic [31:0] ID = 32'hA0B3_0001;

  logic        HCLK = 1'b0;
  logic        HRESETN;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;

  logic [31:0]  prdataA, prdataB;
  logic         preadyA, preadyB, pslverrA, pslverrB, protA, protB;
  logic [255:0] regOutA, regOutB;

  int nChecks = 0;
  int nFail   = 0;

  always #5 HCLK = ~HCLK;

  apb3_reg_responder #(.ADDR_WIDTH(8), .NUM_REGS(8), .WAIT_STATES(2), .ID_VALUE(ID)) dutA (
    .HCLK(HCLK), .HRESETN(HRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdataA), .PREADY(preadyA),
    .PSLVERR(pslverrA), .PROT_ERR(protA), .REG_OUT(regOutA));

  apb3_reg_responder #(.ADDR_WIDTH(8), .NUM_REGS(8), .WAIT_STATES(0), .ID_VALUE(ID)) dutB (
    .HCLK(HCLK), .HRESETN(HRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdataB), .PREADY(preadyB),
    .PSLVERR(pslverrB), .PROT_ERR(protB), .REG_OUT(regOutB));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkW(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nChecks++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdyOf(input bit z);
    return z ? preadyB : preadyA;
  endfunction

  function automatic logic [31:0] prdOf(input bit z);
    return z ? prdataB : prdataA;
  endfunction

  function automatic logic errOf(input bit z);
    return z ? pslverrB : pslverrA;
  endfunction

  // One APB transfer; returns after sampling the completion cycle.
  task automatic xfer(input bit z, input logic wr, input logic [7:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic se, output int n);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    n = 1;
    while (!rdyOf(z) && n < 20) begin
      check("prdata_while_not_ready", prdOf(z), 32'h0);
      check("pslverr_while_not_ready", 32'(errOf(z)), 32'h0);
      @(posedge HCLK); #1;
      n++;
    end
    rd = prdOf(z);
    se = errOf(z);
  endtask

  task automatic idle();
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic doReset();
    @(posedge HCLK); #1;
    HRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    repeat (2) @(posedge HCLK);
    #1 HRESETN = 1'b1;
  endtask

  logic [31:0]  rd;
  logic         se;
  int           n;
  logic [255:0] saved;

  initial begin
    HRESETN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0; PWDATA = '0;
    doReset();

    // Reset state
    check("rst_pready", 32'(preadyA), 32'h0);
    check("rst_prdata", prdataA, 32'h0);
    check("rst_pslverr", 32'(pslverrA), 32'h0);
    check("rst_prot_err", 32'(protA), 32'h0);
    checkW("rst_reg_out", regOutA, {224'h0, ID});

    // Write then read back, two wait states
    xfer(1'b0, 1'b1, 8'h04, 32'hDEADBEEF, rd, se, n);
    check("wr1_ready_cycle", 32'(n), 32'd3);
    check("wr1_pslverr", 32'(se), 32'h0);
    check("wr1_prdata_zero", rd, 32'h0);
    xfer(1'b0, 1'b0, 8'h04, 32'h0, rd, se, n);
    check("rd1_ready_cycle", 32'(n), 32'd3);
    check("rd1_prdata", rd, 32'hDEADBEEF);
    check("rd1_pslverr", 32'(se), 32'h0);
    idle();
    check("rd1_regout", regOutA[63:32], 32'hDEADBEEF);
    check("idle_pready_low", 32'(preadyA), 32'h0);

    // ID register and read-only protection
    xfer(1'b0, 1'b0, 8'h00, 32'h0, rd, se, n);
    check("id_prdata", rd, ID);
    check("id_pslverr", 32'(se), 32'h0);
    xfer(1'b0, 1'b1, 8'h00, 32'h12345678, rd, se, n);
    check("ro_pslverr", 32'(se), 32'h1);
    check("ro_ready_cycle", 32'(n), 32'd3);
    idle();
    check("ro_reg0", regOutA[31:0], ID);

    // Out of range
    xfer(1'b0, 1'b0, 8'h20, 32'h0, rd, se, n);
    check("oor_rd_pslverr", 32'(se), 32'h1);
    check("oor_rd_prdata", rd, 32'h0);
    saved = regOutA;
    xfer(1'b0, 1'b1, 8'h3C, 32'h55AA55AA, rd, se, n);
    check("oor_wr_pslverr", 32'(se), 32'h1);
    idle();
    checkW("oor_wr_regout", regOutA, saved);
    check("no_prot_err_yet", 32'(protA), 32'h0);

    // Drop PSEL in the second wait cycle
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h08; PWDATA = 32'hCAFEF00D;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    check("drop_wait1_pready", 32'(preadyA), 32'h0);
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    check("drop_wait2_pready", 32'(preadyA), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge HCLK); #1;
      check("drop_pready_never", 32'(preadyA), 32'h0);
    end
    check("drop_prot_err", 32'(protA), 32'h1);
    check("drop_reg2_unchanged", regOutA[95:64], 32'h0);

    // PENABLE without setup, then stickiness until reset
    doReset();
    check("rst_clears_prot_err", 32'(protA), 32'h0);
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 8'h04;
    @(posedge HCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    check("nosetup_prot_err", 32'(protA), 32'h1);
    check("nosetup_pready", 32'(preadyA), 32'h0);
    repeat (5) @(posedge HCLK);
    #1 check("prot_err_sticky", 32'(protA), 32'h1);
    doReset();
    check("prot_err_cleared", 32'(protA), 32'h0);

    // Reset during a write's wait phase
    @(posedge HCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h0C; PWDATA = 32'h11112222;
    @(posedge HCLK); #1;
    PENABLE = 1'b1;
    @(posedge HCLK); #1;
    HRESETN = 1'b0;
    @(posedge HCLK); #1;
    check("midrst_pready", 32'(preadyA), 32'h0);
    check("midrst_state_idle", 32'(dutA.state), 32'h0);
    PSEL = 1'b0; PENABLE = 1'b0; HRESETN = 1'b1;
    xfer(1'b0, 1'b0, 8'h0C, 32'h0, rd, se, n);
    check("midrst_reg3_read", rd, 32'h0);
    idle();
    check("midrst_reg3_regout", regOutA[127:96], 32'h0);

    // Zero wait states, back-to-back writes then reads
    doReset();
    for (int k = 1; k <= 4; k++) begin
      xfer(1'b1, 1'b1, 8'(4 * k), 32'h11111111 * 32'(k), rd, se, n);
      check("ws0_wr_ready_cycle", 32'(n), 32'd1);
      check("ws0_wr_pslverr", 32'(se), 32'h0);
    end
    for (int k = 1; k <= 4; k++) begin
      xfer(1'b1, 1'b0, 8'(4 * k), 32'h0, rd, se, n);
      check("ws0_rd_ready_cycle", 32'(n), 32'd1);
      check("ws0_rd_data", rd, 32'h11111111 * 32'(k));
    end
    idle();
    checkW("ws0_regout", regOutB[159:0],
           {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111, ID});
    check("ws0_prot_err", 32'(protB), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
